// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
//   OP_*    : ALUCtl operation codes (4 bits)
//   state_e : controller states of alu_mc
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational datapath: AND, OR, ADD, SUB, SLT, NOR.
// MUL and undefined codes give result 0 and ovf 0 here; the multiplier
// lives in alu_mc.
//   a, b   : first and second operand (b is already the selected op2)
//   op     : ALUCtl code
//   result : operation result
//   ovf    : signed overflow, ADD/SUB only
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH-1:0] op2_eff;
  logic [WIDTH-1:0] sum;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    result  = '0;
    ovf     = 1'b0;
    // Subtraction is addition of the two's complement; the carry out of
    // WIDTH is simply dropped by the WIDTH-bit sum.
    op2_eff = (op == OP_SUB) ? (~b + WIDTH'(1)) : b;
    sum     = a + op2_eff;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD, OP_SUB: begin
        result = sum;
        ovf    = (a[WIDTH-1] == op2_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR: result = ~(a | b);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops finish at
// the acceptance edge; MUL runs a WIDTH-step shift-add iteration.
//   clk, rst_n         : clock, asynchronous active-low reset
//   A, B, imm          : operands; alu_src picks B (0) or imm (1) as op2
//   ALUCtl             : operation select
//   in_valid/in_ready  : request handshake (ready only in IDLE)
//   out_valid/out_ready: result handshake (held in DONE until taken)
//   result, zero, ovf  : registered result fields
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [3:0]       ALUCtl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] core_result;
  logic             core_ovf;

  assign op2      = alu_src ? imm : B;
  assign in_ready = (state == IDLE);

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (A),
    .b      (op2),
    .op     (ALUCtl),
    .result (core_result),
    .ovf    (core_ovf)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the multiplier working registers are reset as well, so an
      // aborted MUL leaves nothing behind that could surface later.
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      result    <= '0;
      zero      <= 1'b1;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (ALUCtl == OP_MUL) begin
              state  <= BUSY;
              cnt    <= CNT_INIT;
              acc    <= '0;
              mcand  <= A;
              mplier <= op2;
            end else begin
              state     <= DONE;
              result    <= core_result;
              zero      <= (core_result == '0);
              ovf       <= core_ovf;
              out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          // WIDTH steps bring cnt to 0; the following edge publishes acc.
          if (cnt == '0) begin
            state     <= DONE;
            result    <= acc;
            zero      <= (acc == '0);
            ovf       <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: a 32-bit and an 8-bit instance
// share clock and reset; hand-computed expectations throughout.
module tb_alu_mc;

  logic clk;
  logic rst_n;

  logic [31:0] a32, b32, imm32, res32;
  logic        src32, iv32, ordy32, rdy32, ov32, z32, ovf32;
  logic [3:0]  ctl32;

  logic [7:0]  a8, b8, imm8, res8;
  logic        src8, iv8, ordy8, rdy8, ov8, z8, ovf8;
  logic [3:0]  ctl8;

  int vectors     = 0;
  int miscompares = 0;

  bit cur_sel8 = 1'b0;
  logic        s_valid, s_ready, s_zero, s_ovf;
  logic [63:0] s_result;

  assign s_valid  = cur_sel8 ? ov8  : ov32;
  assign s_ready  = cur_sel8 ? rdy8 : rdy32;
  assign s_zero   = cur_sel8 ? z8   : z32;
  assign s_ovf    = cur_sel8 ? ovf8 : ovf32;
  assign s_result = cur_sel8 ? {56'd0, res8} : {32'd0, res32};

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .imm(imm32), .alu_src(src32),
    .ALUCtl(ctl32), .in_valid(iv32), .in_ready(rdy32), .out_valid(ov32),
    .out_ready(ordy32), .result(res32), .zero(z32), .ovf(ovf32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .imm(imm8), .alu_src(src8),
    .ALUCtl(ctl8), .in_valid(iv8), .in_ready(rdy8), .out_valid(ov8),
    .out_ready(ordy8), .result(res8), .zero(z8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one request, lets it be accepted,
  // then scrambles the operand inputs to show they are no longer looked at.
  task automatic accept(input string tag, input bit s8, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] im,
                        input logic src, input logic [3:0] ctl);
    int guard = 0;
    cur_sel8 = s8;
    @(negedge clk);
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
    if (s8) begin
      a8 = a[7:0]; b8 = b[7:0]; imm8 = im[7:0]; src8 = src; ctl8 = ctl; iv8 = 1'b1;
    end else begin
      a32 = a[31:0]; b32 = b[31:0]; imm32 = im[31:0]; src32 = src; ctl32 = ctl; iv32 = 1'b1;
    end
    @(posedge clk);
    #1;
    iv32 = 1'b0; iv8 = 1'b0;
    a32 = $urandom; b32 = $urandom; imm32 = $urandom; ctl32 = 4'b0010;
    a8 = 8'($urandom); b8 = 8'($urandom); imm8 = 8'($urandom); ctl8 = 4'b0001;
  endtask

  // Counts clock edges after the acceptance edge until out_valid is seen
  // (0 = high in the cycle right after acceptance).
  task automatic wait_valid(output int n, output bit rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!s_valid && n < 200) begin
      if (s_ready) rdy_seen = 1'b1;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    ordy32 = 1'b1; ordy8 = 1'b1;
    @(posedge clk);
    #1;
    ordy32 = 1'b0; ordy8 = 1'b0;
  endtask

  task automatic run_op(input string tag, input bit s8, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] im, input logic src,
                        input logic [3:0] ctl, input logic [63:0] exp_res,
                        input logic exp_zero, input logic exp_ovf, input int exp_lat);
    int n;
    bit rdy_seen;
    accept(tag, s8, a, b, im, src, ctl);
    wait_valid(n, rdy_seen);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    if (exp_lat > 0) check({tag, "_ready_while_busy"}, 64'(rdy_seen), 64'd0);
    check({tag, "_result"}, s_result, exp_res);
    check({tag, "_zero"}, 64'(s_zero), 64'(exp_zero));
    check({tag, "_ovf"}, 64'(s_ovf), 64'(exp_ovf));
    check({tag, "_ready_done"}, 64'(s_ready), 64'd0);
    take_result();
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0;
    a32 = '0; b32 = '0; imm32 = '0; src32 = 1'b0; ctl32 = '0; iv32 = 1'b0; ordy32 = 1'b0;
    a8 = '0; b8 = '0; imm8 = '0; src8 = 1'b0; ctl8 = '0; iv8 = 1'b0; ordy8 = 1'b0;

    // Reset state
    #12;
    check("rst_result", 64'(res32), 64'd0);
    check("rst_zero", 64'(z32), 64'd1);
    check("rst_ovf", 64'(ovf32), 64'd0);
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst8_zero", 64'(z8), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(rdy32), 64'd1);
    check("ready8_after_rst", 64'(rdy8), 64'd1);

    // Register operands, single-cycle ops
    run_op("and",  0, 6, 5, 99, 0, 4'b0000, 64'd4,  0, 0, 0);
    run_op("or",   0, 6, 5, 99, 0, 4'b0001, 64'd7,  0, 0, 0);
    run_op("add",  0, 6, 5, 99, 0, 4'b0010, 64'd11, 0, 0, 0);
    run_op("sub",  0, 6, 5, 99, 0, 4'b0110, 64'd1,  0, 0, 0);
    run_op("nor",  0, 6, 5, 99, 0, 4'b1100, 64'hFFFF_FFF8, 0, 0, 0);

    // Immediate operand (B holds a decoy)
    run_op("sub_imm", 0, 6, 100, 7, 1, 4'b0110, 64'hFFFF_FFFF, 0, 0, 0);
    run_op("slt_imm", 0, 6, 100, 7, 1, 4'b0111, 64'd1, 0, 0, 0);
    run_op("mul_imm", 0, 6, 100, 7, 1, 4'b1000, 64'd42, 0, 0, 33);

    // Boundaries
    run_op("add_ovf",  0, 64'h7FFF_FFFF, 1, 0, 0, 4'b0010, 64'h8000_0000, 0, 1, 0);
    run_op("sub_ovf",  0, 64'h8000_0000, 1, 0, 0, 4'b0110, 64'h7FFF_FFFF, 0, 1, 0);
    run_op("sub_zero", 0, 5, 5, 0, 0, 4'b0110, 64'd0, 1, 0, 0);
    run_op("slt_neg",  0, 64'hFFFF_FFFF, 1, 0, 0, 4'b0111, 64'd1, 0, 0, 0);
    run_op("undef",    0, 6, 5, 0, 0, 4'b1111, 64'd0, 1, 0, 0);

    // Back-pressure in DONE; a pending request must wait for IDLE
    accept("stall", 0, 6, 5, 0, 0, 4'b0010);
    wait_valid(n, seen);
    check("stall_first_result", s_result, 64'd11);
    @(negedge clk);
    a32 = 12; b32 = 10; src32 = 1'b0; ctl32 = 4'b0000; iv32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_result", s_result, 64'd11);
      check("stall_valid", 64'(s_valid), 64'd1);
      check("stall_ready", 64'(s_ready), 64'd0);
    end
    ordy32 = 1'b1;
    @(posedge clk);
    #1;
    ordy32 = 1'b0;
    @(negedge clk);
    check("release_valid", 64'(s_valid), 64'd0);
    check("release_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    @(negedge clk);
    check("pending_result", s_result, 64'd8);
    check("pending_valid", 64'(s_valid), 64'd1);
    take_result();

    // Reset in the middle of a MUL
    accept("mul_abort", 0, 6, 7, 0, 0, 4'b1000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_result", 64'(res32), 64'd0);
    check("abort_zero", 64'(z32), 64'd1);
    check("abort_ovf", 64'(ovf32), 64'd0);
    check("abort_valid", 64'(ov32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 64'(rdy32), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_op("add_after_rst", 0, 2, 3, 0, 0, 4'b0010, 64'd5, 0, 0, 0);

    // 8-bit instance
    run_op("mul8_ff", 1, 15, 0, 17, 1, 4'b1000, 64'hFF, 0, 0, 9);
    run_op("mul8_wrap", 1, 16, 16, 0, 0, 4'b1000, 64'd0, 1, 0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
